object_table: RTL and testbench

//  Parametrised handle-to-address translation table; successor to the per-handle cell array.

---
 rtl/object_table.sv | 178 +++++++++++++++++
 tb/tb_object_table.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_table.sv
// Handle-to-address translation table with a valid/ready command channel and a registered response.
// Define OBJECT_TABLE_LIMIT_EN to add per-entry offset limits checked by TRANSLATE.
module object_table #(
  parameter  int ADDR_WIDTH  = 64,
  parameter  int HNDL_WIDTH  = 8,
  parameter  int NUM_ENTRIES = 16,
  localparam int OFF_WIDTH   = ADDR_WIDTH-HNDL_WIDTH-1,
  localparam int CNT_WIDTH   = $clog2(NUM_ENTRIES+1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [HNDL_WIDTH-1:0] cmd_handle,
  input  logic [OFF_WIDTH-1:0]  cmd_data,
`ifdef OBJECT_TABLE_LIMIT_EN
  input  logic [OFF_WIDTH-1:0]  cmd_limit,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [OFF_WIDTH-1:0]  rsp_data,
  output logic [HNDL_WIDTH-1:0] rsp_handle,
  output logic                  rsp_error,
  output logic [CNT_WIDTH-1:0]  free_count
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [HNDL_WIDTH:0] NUM_E = (HNDL_WIDTH+1)'(NUM_ENTRIES);

  localparam logic [1:0] OP_TRANS = 2'b00;
  localparam logic [1:0] OP_ALLOC = 2'b01;
  localparam logic [1:0] OP_FREE  = 2'b10;
  localparam logic [1:0] OP_RDB   = 2'b11;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [OFF_WIDTH-1:0]   r_base [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0]   r_free_cnt;
  logic [OFF_WIDTH-1:0]   r_rsp_data;
  logic [HNDL_WIDTH-1:0]  r_rsp_hndl;
  logic                   r_rsp_err;

  logic                  w_accept;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_hit;
  logic                  w_lim_ok;
  logic                  w_has_free;
  logic [IDX_W-1:0]      w_free_idx;
  logic                  w_set;
  logic                  w_clr;
  logic [OFF_WIDTH-1:0]  w_rsp_data;
  logic [HNDL_WIDTH-1:0] w_rsp_hndl;
  logic                  w_rsp_err;

  assign rsp_valid  = (r_state == S_HOLD);
  assign cmd_ready  = !rsp_valid | rsp_ready;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_in_range = {1'b0, cmd_handle} < NUM_E;
  assign w_idx      = cmd_handle[IDX_W-1:0];
  assign w_hit      = w_in_range && r_valid[w_idx];
  assign rsp_data   = r_rsp_data;
  assign rsp_handle = r_rsp_hndl;
  assign rsp_error  = r_rsp_err;
  assign free_count = r_free_cnt;

`ifdef OBJECT_TABLE_LIMIT_EN
  logic [OFF_WIDTH-1:0] r_limit [NUM_ENTRIES];
  assign w_lim_ok = cmd_data < r_limit[w_idx];
`else
  assign w_lim_ok = 1'b1;
`endif

  // Descending scan leaves the lowest free index as the winner
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_rsp_data = '0;
    w_rsp_err  = 1'b0;
    w_rsp_hndl = cmd_handle;
    w_set      = 1'b0;
    w_clr      = 1'b0;
    unique case (cmd_op)
      OP_ALLOC: begin
        if (w_has_free) begin
          w_set      = 1'b1;
          w_rsp_hndl = HNDL_WIDTH'(w_free_idx);
        end else begin
          w_rsp_err  = 1'b1;
          w_rsp_hndl = '0;
        end
      end
      OP_FREE: begin
        if (w_hit) begin
          w_clr      = 1'b1;
          w_rsp_data = r_base[w_idx];
        end else begin
          w_rsp_err  = 1'b1;
        end
      end
      OP_TRANS: begin
        if (w_hit && w_lim_ok) w_rsp_data = r_base[w_idx] + cmd_data;
        else                   w_rsp_err  = 1'b1;
      end
      OP_RDB: begin
        if (w_hit) w_rsp_data = r_base[w_idx];
        else       w_rsp_err  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_HOLD;
      S_HOLD: if (!w_accept && rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rsp_data <= '0;
      r_rsp_hndl <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rsp_data <= w_rsp_data;
        r_rsp_hndl <= w_rsp_hndl;
        r_rsp_err  <= w_rsp_err;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid    <= '0;
      r_free_cnt <= CNT_WIDTH'(NUM_ENTRIES);
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_base[i] <= '0;
`ifdef OBJECT_TABLE_LIMIT_EN
        r_limit[i] <= '0;
`endif
      end
    end else if (w_accept) begin
      if (w_set) begin
        r_valid[w_free_idx] <= 1'b1;
        r_base[w_free_idx]  <= cmd_data;
`ifdef OBJECT_TABLE_LIMIT_EN
        r_limit[w_free_idx] <= cmd_limit;
`endif
        r_free_cnt <= r_free_cnt - CNT_WIDTH'(1);
      end
      if (w_clr) begin
        r_valid[w_idx] <= 1'b0;
        r_free_cnt     <= r_free_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_object_table.sv
// Randomised self-checking bench for object_table against an array-based table model.
module tb_object_table;

`ifdef OBJECT_TABLE_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  localparam logic [1:0] TR = 2'b00;
  localparam logic [1:0] AL = 2'b01;
  localparam logic [1:0] FR = 2'b10;
  localparam logic [1:0] RB = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_handle = '0;
  logic [54:0] cmd_data = '0;
  logic [54:0] cmd_lim = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [54:0] rsp_data;
  logic [7:0]  rsp_handle;
  logic        rsp_error;
  logic [4:0]  free_count;

  int n_pass = 0;
  int n_total = 0;

  bit          m_valid [16];
  logic [54:0] m_base  [16];
  logic [54:0] m_lim   [16];
  logic        e_err;
  logic [54:0] e_data;
  logic [7:0]  e_hndl;

  always #5 clock = ~clock;

  object_table dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_handle(cmd_handle),
    .cmd_data(cmd_data),
`ifdef OBJECT_TABLE_LIMIT_EN
    .cmd_limit(cmd_lim),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_handle(rsp_handle),
    .rsp_error(rsp_error), .free_count(free_count)
  );

  function automatic logic [4:0] m_free();
    int c = 0;
    for (int i = 0; i < 16; i++) if (!m_valid[i]) c++;
    return 5'(c);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_base[i]  = '0;
      m_lim[i]   = '0;
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [7:0] h,
                       input logic [54:0] d, input logic [54:0] lim);
    int hi = int'(h);
    int found = -1;
    bit live = (hi < 16) && m_valid[hi % 16];
    e_err = 1'b0;
    e_data = '0;
    e_hndl = h;
    case (op)
      AL: begin
        for (int i = 0; i < 16; i++)
          if (!m_valid[i] && found < 0) found = i;
        if (found < 0) begin
          e_err = 1'b1;
          e_hndl = '0;
        end else begin
          m_valid[found] = 1'b1;
          m_base[found] = d;
          m_lim[found] = lim;
          e_hndl = 8'(found);
        end
      end
      FR: begin
        if (live) begin
          e_data = m_base[hi];
          m_valid[hi] = 1'b0;
        end else e_err = 1'b1;
      end
      TR: begin
        if (live && (!LIM || d < m_lim[hi])) e_data = m_base[hi] + d;
        else e_err = 1'b1;
      end
      default: begin
        if (live) e_data = m_base[hi];
        else e_err = 1'b1;
      end
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input int h,
                       input logic [54:0] d, input logic [54:0] lim);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_handle = h[7:0];
    cmd_data = d;
    cmd_lim = lim;
    rsp_ready = 1'b1;
    model(op, h[7:0], d, cmd_lim);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_clear();
    repeat (2) @(posedge clock);
    #1;
    n_total++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_handle !== '0 ||
        rsp_error !== 1'b0 || free_count !== 5'd16 || cmd_ready !== 1'b1)
      $display("FAIL reset: v=%b d=%h h=%0d e=%b fc=%0d rdy=%b want 0 0 0 0 16 1",
               rsp_valid, rsp_data, rsp_handle, rsp_error, free_count, cmd_ready);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      issue(AL, 0, 55'h100 * i, 55'h40);
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_handle !== i[7:0] ||
          free_count !== 5'(15 - i) || rsp_data !== e_data)
        $display("FAIL fill%0d: v=%b e=%b h=%0d fc=%0d want h=%0d fc=%0d",
                 i, rsp_valid, rsp_error, rsp_handle, free_count, i, 15 - i);
      else n_pass++;
    end
  endtask

  task automatic test_full();
    issue(AL, 3, 55'h999, 55'h1);
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_handle !== 8'd0 ||
        free_count !== 5'd0)
      $display("FAIL full: v=%b e=%b h=%0d fc=%0d want 1 1 0 0",
               rsp_valid, rsp_error, rsp_handle, free_count);
    else n_pass++;
  endtask

  task automatic test_free_realloc();
    issue(FR, 5, 55'h0, 55'h0);
    n_total++;
    if (rsp_error !== 1'b0 || rsp_data !== 55'h500 || rsp_handle !== 8'd5 ||
        free_count !== 5'd1)
      $display("FAIL free5: e=%b d=%h h=%0d fc=%0d want 0 500 5 1",
               rsp_error, rsp_data, rsp_handle, free_count);
    else n_pass++;
    issue(AL, 9, 55'hABC, 55'h10);
    n_total++;
    if (rsp_error !== 1'b0 || rsp_handle !== 8'd5 || free_count !== 5'd0)
      $display("FAIL realloc: e=%b h=%0d fc=%0d want 0 5 0",
               rsp_error, rsp_handle, free_count);
    else n_pass++;
    issue(TR, 5, 55'h4, 55'h0);
    n_total++;
    if (rsp_error !== 1'b0 || rsp_data !== 55'hAC0 || rsp_handle !== 8'd5)
      $display("FAIL xlate5: e=%b d=%h h=%0d want 0 ac0 5",
               rsp_error, rsp_data, rsp_handle);
    else n_pass++;
  endtask

  task automatic test_errors();
    int hs [5] = '{7, 7, 20, 20, 6};
    logic [1:0] os [5] = '{FR, FR, TR, RB, RB};
    for (int i = 0; i < 5; i++) begin
      issue(os[i], hs[i], 55'h3, 55'h0);
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_error !== e_err || rsp_data !== e_data ||
          rsp_handle !== e_hndl || free_count !== m_free())
        $display("FAIL err%0d: e=%b d=%h h=%0d fc=%0d want e=%b d=%h h=%0d fc=%0d",
                 i, rsp_error, rsp_data, rsp_handle, free_count,
                 e_err, e_data, e_hndl, m_free());
      else n_pass++;
    end
    n_total++;
    if (m_free() !== 5'd1 || m_base[6] !== 55'h600 || free_count !== 5'd1)
      $display("FAIL err_table: fc=%0d want 1", free_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic        a_err;
    logic [54:0] a_data;
    logic [7:0]  a_hndl;
    int          hs [3] = '{4, 6, 8};
    issue(RB, 3, 55'h0, 55'h0);
    a_err = e_err;
    a_data = e_data;
    a_hndl = e_hndl;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = RB;
    cmd_handle = 8'd4;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_total++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_error !== a_err ||
          rsp_data !== a_data || rsp_handle !== a_hndl)
        $display("FAIL stall%0d: rdy=%b v=%b d=%h h=%0d want 0 1 %h %0d",
                 c, cmd_ready, rsp_valid, rsp_data, rsp_handle, a_data, a_hndl);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      cmd_valid = 1'b1;
      cmd_op = RB;
      cmd_handle = hs[i][7:0];
      rsp_ready = 1'b1;
      model(RB, hs[i][7:0], 55'h0, 55'h0);
      @(posedge clock);
      #1;
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_error !== e_err || rsp_data !== e_data ||
          rsp_handle !== e_hndl)
        $display("FAIL drain%0d: v=%b e=%b d=%h h=%0d want e=%b d=%h h=%0d",
                 i, rsp_valid, rsp_error, rsp_data, rsp_handle,
                 e_err, e_data, e_hndl);
      else n_pass++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  op = 2'($urandom_range(0, 3));
      int          h  = $urandom_range(0, 19);
      logic [54:0] d  = 55'({$urandom, $urandom});
      logic [54:0] l  = 55'({$urandom, $urandom});
      if (op == TR && $urandom_range(0, 1) == 0) d = 55'($urandom_range(0, 255));
      issue(op, h, d, l);
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_error !== e_err || rsp_data !== e_data ||
          rsp_handle !== e_hndl || free_count !== m_free())
        $display("FAIL rand%0d op=%0d: e=%b d=%h h=%0d fc=%0d want e=%b d=%h h=%0d fc=%0d",
                 i, op, rsp_error, rsp_data, rsp_handle, free_count,
                 e_err, e_data, e_hndl, m_free());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    issue(AL, 0, 55'h77, 55'h5);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = AL;
    rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    n_total++;
    if (rsp_valid !== 1'b0 || free_count !== 5'd16 || cmd_ready !== 1'b1)
      $display("FAIL midreset: v=%b fc=%0d rdy=%b want 0 16 1",
               rsp_valid, free_count, cmd_ready);
    else n_pass++;
    m_clear();
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    n_total++;
    if (rsp_valid !== 1'b0)
      $display("FAIL replay: v=%b want 0", rsp_valid);
    else n_pass++;
    issue(RB, 0, 55'h0, 55'h0);
    n_total++;
    if (rsp_error !== 1'b1 || rsp_data !== 55'h0 || free_count !== 5'd16)
      $display("FAIL postreset: e=%b d=%h fc=%0d want 1 0 16",
               rsp_error, rsp_data, free_count);
    else n_pass++;
  endtask

  task automatic test_limit();
    logic [54:0] want_ok = LIM ? 55'h17 : 55'h18;
    issue(AL, 0, 55'h10, 55'h8);
    n_total++;
    if (rsp_error !== 1'b0 || rsp_handle !== 8'd0)
      $display("FAIL lim_alloc: e=%b h=%0d want 0 0", rsp_error, rsp_handle);
    else n_pass++;
    issue(TR, 0, LIM ? 55'h7 : 55'h8, 55'h0);
    n_total++;
    if (rsp_error !== 1'b0 || rsp_data !== want_ok)
      $display("FAIL lim_ok: e=%b d=%h want 0 %h", rsp_error, rsp_data, want_ok);
    else n_pass++;
    issue(TR, 0, 55'h8, 55'h0);
    n_total++;
    if (rsp_error !== e_err || rsp_data !== e_data)
      $display("FAIL lim_edge: e=%b d=%h want %b %h",
               rsp_error, rsp_data, e_err, e_data);
    else n_pass++;
    issue(RB, 0, 55'h0, 55'h0);
    n_total++;
    if (rsp_error !== 1'b0 || rsp_data !== 55'h10)
      $display("FAIL lim_base: e=%b d=%h want 0 10", rsp_error, rsp_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full();
    test_free_realloc();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_limit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
